sdc_cmd_seq: RTL and testbench

SD card SPI-mode command sequencer. Sits between a host command interface and the byte-level SD card SPI controller's register port, which it drives exclusively. Frames one SD command (6 bytes), polls for the R1 response within a bounded number of bytes, then appends the trailing 8-clock byte. The frame is produced as a series of single-cycle register accesses.

---
 rtl/sdc_cmd_seq.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sdc_cmd_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sdc_cmd_seq.sv
// sdc_cmd_seq -- SD card SPI-mode command sequencer.
//
// Frames one SD command (6 bytes) onto the byte-level SPI controller register
// port, polls for the R1 response for at most NCR_MAX bytes, then clocks one
// trailing 0xFF byte. Every controller access is a single-cycle strobe.
//
// Optional feature macro: SDC_CRC7_EN
//   defined   : byte 5 = {CRC7, 1}, CRC7 computed serially (1 bit/cycle)
//               during CSON/FLUSH; FLUSH is stretched until all 40 bits are in.
//   undefined : byte 5 = 0x95 (CMD0), 0x87 (CMD8), else 0x01.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle command request (ignored while busy)
//   cmd_idx, arg      SD command index and argument
//   fast, keep_cs     SCLK speed select, keep chip select after the command
//   busy, done        sequence in progress, one-cycle completion pulse
//   r1, timeout       R1 byte (0xFF on timeout) and timeout flag
//   spi_stb/we/addr   controller access strobe, write, register select
//   spi_wdat          controller write data (0 on reads)
//   spi_rdat          controller read data, combinational on spi_addr
module sdc_cmd_seq #(
  parameter int unsigned NCR_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] arg,
  input  logic        fast,
  input  logic        keep_cs,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout,
  output logic        spi_stb,
  output logic        spi_we,
  output logic        spi_addr,
  output logic [7:0]  spi_wdat,
  input  logic [7:0]  spi_rdat
);

  localparam logic [7:0] NCR_LIM = 8'(NCR_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_CSON, S_FLUSH, S_WR, S_POLL, S_RD, S_NEXT, S_TAIL, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_CMD, PH_RESP, PH_TAIL} phase_t;

  state_t      state, state_nxt;
  phase_t      phase, phase_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [7:0]  cnt, cnt_nxt, cnt_inc;
  logic [7:0]  r1_res, r1_res_nxt;
  logic        to_res, to_res_nxt;

  logic [5:0]  cmd_l;
  logic [31:0] arg_l;
  logic        fast_l;
  logic        keep_l;
  logic [7:0]  samp;
  logic [7:0]  crc_byte;
  logic        crc_busy;

  logic        busy_nxt, done_nxt, stb_nxt, we_nxt, addr_nxt, fast_sel;
  logic [7:0]  wdat_nxt;

  function automatic logic [7:0] frame_byte(input logic [2:0] i,
                                            input logic [5:0] c,
                                            input logic [31:0] a,
                                            input logic [7:0] b5);
    case (i)
      3'd0:    frame_byte = {2'b01, c};
      3'd1:    frame_byte = a[31:24];
      3'd2:    frame_byte = a[23:16];
      3'd3:    frame_byte = a[15:8];
      3'd4:    frame_byte = a[7:0];
      3'd5:    frame_byte = b5;
      default: frame_byte = 8'hFF;
    endcase
  endfunction

`ifdef SDC_CRC7_EN
  logic [39:0] crc_sr;
  logic [6:0]  crc;
  logic [5:0]  crc_cnt;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    crc7_step = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // One frame bit per cycle while in CSON/FLUSH; reloaded on every start.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      crc_sr  <= {2'b01, cmd_idx, arg};
      crc     <= 7'd0;
      crc_cnt <= 6'd0;
    end else if ((state == S_CSON || state == S_FLUSH) && crc_cnt != 6'd40) begin
      crc     <= crc7_step(crc, crc_sr[39]);
      crc_sr  <= {crc_sr[38:0], 1'b0};
      crc_cnt <= crc_cnt + 6'd1;
    end
  end

  assign crc_byte = {crc, 1'b1};
  // The FLUSH cycle with crc_cnt == 39 shifts in the final bit.
  assign crc_busy = (crc_cnt != 6'd39);
`else
  always_comb begin
    crc_byte = 8'h01;
    if (cmd_l == 6'd0)      crc_byte = 8'h95;
    else if (cmd_l == 6'd8) crc_byte = 8'h87;
  end
  assign crc_busy = 1'b0;
`endif

  // Next-state and next-output logic; outputs are decoded from the state being
  // entered so that every port is driven straight from a flop.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    r1_res_nxt = r1_res;
    to_res_nxt = to_res;
    cnt_inc    = (cnt == NCR_LIM) ? cnt : cnt + 8'd1;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_CSON;
          phase_nxt  = PH_CMD;
          idx_nxt    = 3'd0;
          cnt_nxt    = 8'd0;
          r1_res_nxt = 8'hFF;
          to_res_nxt = 1'b0;
        end
      end
      S_CSON:  state_nxt = S_FLUSH;
      S_FLUSH: if (!crc_busy) state_nxt = S_WR;
      S_WR:    state_nxt = S_POLL;
      S_POLL:  if (spi_rdat[0]) state_nxt = S_RD;
      S_RD:    state_nxt = S_NEXT;
      S_NEXT: begin
        case (phase)
          PH_CMD: begin
            state_nxt = S_WR;
            if (idx == 3'd5) begin
              phase_nxt = PH_RESP;
              cnt_nxt   = 8'd0;
            end else begin
              idx_nxt = idx + 3'd1;
            end
          end
          PH_RESP: begin
            if (!samp[7]) begin
              r1_res_nxt = samp;
              state_nxt  = S_TAIL;
            end else begin
              cnt_nxt = cnt_inc;
              if (cnt_inc == NCR_LIM) begin
                r1_res_nxt = 8'hFF;
                to_res_nxt = 1'b1;
                state_nxt  = S_TAIL;
              end else begin
                state_nxt = S_WR;
              end
            end
          end
          default: state_nxt = S_DONE;
        endcase
      end
      S_TAIL: begin
        phase_nxt = PH_TAIL;
        state_nxt = S_WR;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    fast_sel = (state == S_IDLE) ? fast : fast_l;
    stb_nxt  = 1'b0;
    we_nxt   = 1'b0;
    addr_nxt = 1'b0;
    wdat_nxt = 8'h00;
    case (state_nxt)
      S_CSON: begin
        stb_nxt  = 1'b1;
        we_nxt   = 1'b1;
        wdat_nxt = {6'd0, fast_sel, 1'b1};
      end
      S_FLUSH: begin
        // Only the first FLUSH cycle reads; any stretch is idle waiting on CRC.
        if (state != S_FLUSH) begin
          stb_nxt  = 1'b1;
          addr_nxt = 1'b1;
        end
      end
      S_WR: begin
        stb_nxt  = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = 1'b1;
        wdat_nxt = (phase_nxt == PH_CMD) ? frame_byte(idx_nxt, cmd_l, arg_l, crc_byte)
                                         : 8'hFF;
      end
      S_POLL: stb_nxt = 1'b1;
      S_RD: begin
        stb_nxt  = 1'b1;
        addr_nxt = 1'b1;
      end
      S_TAIL: begin
        if (!keep_l) begin
          stb_nxt  = 1'b1;
          we_nxt   = 1'b1;
          wdat_nxt = {6'd0, fast_l, 1'b0};
        end
      end
      default: ;
    endcase

    busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= PH_CMD;
      idx      <= 3'd0;
      cnt      <= 8'd0;
      r1_res   <= 8'hFF;
      to_res   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      r1       <= 8'hFF;
      timeout  <= 1'b0;
      spi_stb  <= 1'b0;
      spi_we   <= 1'b0;
      spi_addr <= 1'b0;
      spi_wdat <= 8'h00;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      r1_res   <= r1_res_nxt;
      to_res   <= to_res_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      spi_stb  <= stb_nxt;
      spi_we   <= we_nxt;
      spi_addr <= addr_nxt;
      spi_wdat <= wdat_nxt;
      if (state == S_IDLE && start) timeout <= 1'b0;
      // Publish the result on the last read so it is stable one cycle before done.
      if (state == S_RD && phase == PH_TAIL) begin
        r1      <= r1_res;
        timeout <= to_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cmd_l  <= cmd_idx;
      arg_l  <= arg;
      fast_l <= fast;
      keep_l <= keep_cs;
    end
    if (state == S_RD) samp <= spi_rdat;
  end

endmodule

// File: tb/tb_sdc_cmd_seq.sv
module tb_sdc_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  cmd_idx;
  logic [31:0] arg;
  logic        fast;
  logic        keep_cs;
  logic        busy, done, timeout;
  logic [7:0]  r1;
  logic        spi_stb, spi_we, spi_addr;
  logic [7:0]  spi_wdat, spi_rdat;

  always #5 clk = ~clk;

  sdc_cmd_seq #(.NCR_MAX(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_idx(cmd_idx), .arg(arg),
    .fast(fast), .keep_cs(keep_cs), .busy(busy), .done(done), .r1(r1),
    .timeout(timeout), .spi_stb(spi_stb), .spi_we(spi_we), .spi_addr(spi_addr),
    .spi_wdat(spi_wdat), .spi_rdat(spi_rdat)
  );

  // SPI controller + card model
  logic       m_rdy, m_cs;
  logic [7:0] m_rxd, m_pend;
  int         m_bsy;
  int         wr_tot, ctrl_tot, viol;
  logic [7:0] data_log [0:511];
  logic [7:0] ctrl_log [0:511];
  int         ctrl_wr  [0:511];
  int         cmd_base, resp_k;
  logic [7:0] resp_val;

  assign spi_rdat = spi_addr ? m_rxd : {7'd0, m_rdy};

  always @(posedge clk) begin
    if (rst) begin
      m_rdy <= 1'b0;
      m_cs  <= 1'b0;
      m_bsy <= 0;
      m_rxd <= 8'hFF;
    end else begin
      if (m_bsy != 0) begin
        m_bsy <= m_bsy - 1;
        if (m_bsy == 1) begin
          m_rdy <= 1'b1;
          m_rxd <= m_pend;
        end
      end
      if (spi_stb && spi_we && !spi_addr) begin
        m_cs <= spi_wdat[0];
        ctrl_log[ctrl_tot] <= spi_wdat;
        ctrl_wr[ctrl_tot]  <= wr_tot;
        ctrl_tot <= ctrl_tot + 1;
      end
      if (spi_stb && spi_we && spi_addr) begin
        data_log[wr_tot] <= spi_wdat;
        wr_tot <= wr_tot + 1;
        m_bsy  <= 4;
        m_pend <= ((wr_tot - cmd_base) == resp_k) ? resp_val : 8'hFF;
      end
      if (spi_stb && !spi_we && spi_addr) m_rdy <= 1'b0;
    end
    if (spi_stb && !busy) viol <= viol + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] a;
    logic        f;
    logic        keep;
    logic        extra;
    int          rk;
    logic [7:0]  rv;
    int          nwr;
    logic [7:0]  b0;
    logic [7:0]  b5;
    logic [7:0]  r1;
    logic        to;
    int          nctrl;
    logic [7:0]  c0;
    logic [7:0]  c1;
  } vec_t;

  vec_t vecs [0:4];

`ifdef SDC_CRC7_EN
  localparam logic [7:0] CMD55_B5 = 8'h65;
`else
  localparam logic [7:0] CMD55_B5 = 8'h01;
`endif

  task automatic run(input vec_t v, input string tag);
    int  cb, ccb, nwr, nctrl;
    bit  got;
    bit  ff_ok;
    logic [7:0] r1_at_done;
    cb  = wr_tot;
    ccb = ctrl_tot;
    cmd_base = wr_tot;
    resp_k   = v.rk;
    resp_val = v.rv;
    @(negedge clk);
    cmd_idx = v.cmd; arg = v.a; fast = v.f; keep_cs = v.keep; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    chk({tag, " timeout_cleared"}, {31'd0, timeout}, 32'd0);
    if (v.extra) begin
      repeat (30) @(negedge clk);
      cmd_idx = 6'd17; arg = 32'hDEADBEEF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, " done_seen"}, {31'd0, got}, 32'd1);
    if (!got) return;
    nwr   = wr_tot - cb;
    nctrl = ctrl_tot - ccb;
    r1_at_done = r1;
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " r1"}, {24'd0, r1}, {24'd0, v.r1});
    chk({tag, " timeout"}, {31'd0, timeout}, {31'd0, v.to});
    chk({tag, " n_data_writes"}, nwr, v.nwr);
    chk({tag, " byte0"}, {24'd0, data_log[cb]}, {24'd0, v.b0});
    chk({tag, " arg_bytes"}, {data_log[cb+1], data_log[cb+2], data_log[cb+3], data_log[cb+4]}, v.a);
    chk({tag, " byte5"}, {24'd0, data_log[cb+5]}, {24'd0, v.b5});
    ff_ok = 1'b1;
    for (int k = 6; k < nwr; k++) if (data_log[cb+k] !== 8'hFF) ff_ok = 1'b0;
    chk({tag, " resp_tail_ff"}, {31'd0, ff_ok}, 32'd1);
    chk({tag, " n_ctrl_writes"}, nctrl, v.nctrl);
    chk({tag, " ctrl_cs_on"}, {24'd0, ctrl_log[ccb]}, {24'd0, v.c0});
    if (v.nctrl == 2) begin
      chk({tag, " ctrl_cs_off"}, {24'd0, ctrl_log[ccb+1]}, {24'd0, v.c1});
      chk({tag, " cs_off_before_tail"}, ctrl_wr[ccb+1], cb + v.nwr - 1);
    end
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, " r1_held"}, {24'd0, r1}, {24'd0, r1_at_done});
  endtask

  initial begin
    bit seen_done, got;
    wr_tot = 0; ctrl_tot = 0; viol = 0;
    cmd_base = 0; resp_k = 255; resp_val = 8'hFF;
    rst = 1'b1; start = 1'b0; cmd_idx = 6'd0; arg = 32'd0; fast = 1'b0; keep_cs = 1'b0;

    //          cmd    arg           f  k  x  rk   rv     nwr b0     b5        r1     to nc c0     c1
    vecs[0] = '{6'd0,  32'h00000000, 0, 0, 0, 7,   8'h01, 9,  8'h40, 8'h95,    8'h01, 0, 2, 8'h01, 8'h00};
    vecs[1] = '{6'd8,  32'h000001AA, 1, 0, 0, 8,   8'h01, 10, 8'h48, 8'h87,    8'h01, 0, 2, 8'h03, 8'h02};
    vecs[2] = '{6'd55, 32'h00000000, 0, 0, 0, 6,   8'h00, 8,  8'h77, CMD55_B5, 8'h00, 0, 2, 8'h01, 8'h00};
    vecs[3] = '{6'd0,  32'h00000000, 0, 0, 0, 255, 8'hFF, 15, 8'h40, 8'h95,    8'hFF, 1, 2, 8'h01, 8'h00};
    vecs[4] = '{6'd0,  32'h00000000, 1, 1, 1, 6,   8'h05, 8,  8'h40, 8'h95,    8'h05, 0, 1, 8'h03, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst r1", {24'd0, r1}, 32'hFF);
    chk("rst timeout", {31'd0, timeout}, 32'd0);
    chk("rst spi", {spi_stb, spi_we, spi_addr, spi_wdat}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset while polling for byte 3 (fourth frame byte) of a CMD0.
    cmd_base = wr_tot; resp_k = 7; resp_val = 8'h01;
    cmd_idx = 6'd0; arg = 32'd0; fast = 1'b0; keep_cs = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0; seen_done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ((wr_tot - cmd_base) == 4 && spi_stb && !spi_we && !spi_addr) begin got = 1'b1; break; end
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("midrst reached_poll", {31'd0, got}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst r1", {24'd0, r1}, 32'hFF);
    chk("midrst timeout", {31'd0, timeout}, 32'd0);
    chk("midrst spi", {spi_stb, spi_we, spi_addr, spi_wdat}, 32'd0);
    chk("midrst cs_released", {31'd0, m_cs}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("midrst no_done", {31'd0, seen_done}, 32'd0);
    run(vecs[0], "after_rst");

    chk("stb_only_while_busy", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
